// File: rtl/cpu_ctrl_pkg.sv
// Shared decode definitions: RV32 opcodes, control-word bit positions
// and the RegSrc write-back select encodings.
package cpu_ctrl_pkg;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam int CTRL_HIT       = 31;
    localparam int CTRL_REGWRITE  = 18;
    localparam int CTRL_REGSRC_HI = 17;
    localparam int CTRL_REGSRC_LO = 16;
    localparam int CTRL_MEMREAD   = 13;
    localparam int CTRL_MEMWRITE  = 12;
    localparam int CTRL_BLT       = 11;
    localparam int CTRL_JALR      = 10;
    localparam int CTRL_JAL       = 9;
    localparam int CTRL_BEQ       = 8;
    localparam int CTRL_ALUSRC0   = 5;
    localparam int CTRL_ALUSRC    = 4;
    localparam int CTRL_ALUOP     = 0;

    // Write-back source select carried in the RegSrc field
    typedef enum logic [1:0] {
        REGSRC_PC4 = 2'd0,
        REGSRC_MEM = 2'd1,
        REGSRC_ALU = 2'd2
    } regsrc_e;

endpackage

// File: rtl/decode_ctrl_comb.sv
// Purely combinational decoder: instruction word and cache-hit flag in,
// control word and register-usage flags out.
module decode_ctrl_comb
    import cpu_ctrl_pkg::*;
#(
    parameter int CTRL_W = 32
) (
    input  logic [31:0]       instr_i,
    input  logic              hit_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic              uses_rs1_o,
    output logic              uses_rs2_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unusedFields;

    assign opcode       = instr_i[6:0];
    assign funct3       = instr_i[14:12];
    assign funct7       = instr_i[31:25];
    assign unusedFields = ^instr_i[24:7];

    // Opcode decode into control bits; unknown opcodes carry only the hit flag
    always_comb begin
        ctrl_o           = '0;
        ctrl_o[CTRL_HIT] = hit_i;
        case (opcode)
            OPC_OP_IMM: begin
                ctrl_o[CTRL_REGWRITE]                 = 1'b1;
                ctrl_o[CTRL_REGSRC_HI:CTRL_REGSRC_LO] = REGSRC_ALU;
                ctrl_o[CTRL_ALUSRC]                   = 1'b1;
            end
            OPC_OP: begin
                ctrl_o[CTRL_REGWRITE]                 = 1'b1;
                ctrl_o[CTRL_REGSRC_HI:CTRL_REGSRC_LO] = REGSRC_ALU;
                ctrl_o[CTRL_ALUOP]                    = (funct7 != 7'd0);
            end
            OPC_JAL, OPC_JALR: begin
                ctrl_o[CTRL_REGWRITE]                 = 1'b1;
                ctrl_o[CTRL_REGSRC_HI:CTRL_REGSRC_LO] = REGSRC_PC4;
                ctrl_o[CTRL_ALUSRC]                   = 1'b1;
                ctrl_o[CTRL_JAL]                      = (opcode == OPC_JAL);
                ctrl_o[CTRL_JALR]                     = (opcode == OPC_JALR);
            end
            OPC_BRANCH: begin
                ctrl_o[CTRL_ALUOP] = 1'b1;
                ctrl_o[CTRL_BEQ]   = (funct3 == 3'd0);
                ctrl_o[CTRL_BLT]   = (funct3 != 3'd0);
            end
            OPC_LOAD: begin
                ctrl_o[CTRL_REGWRITE]                 = 1'b1;
                ctrl_o[CTRL_REGSRC_HI:CTRL_REGSRC_LO] = REGSRC_MEM;
                ctrl_o[CTRL_MEMREAD]                  = 1'b1;
                ctrl_o[CTRL_ALUSRC]                   = 1'b1;
            end
            OPC_STORE: begin
                ctrl_o[CTRL_MEMWRITE] = 1'b1;
                ctrl_o[CTRL_ALUSRC]   = 1'b1;
            end
            OPC_AUIPC: begin
                ctrl_o[CTRL_REGWRITE]                 = 1'b1;
                ctrl_o[CTRL_REGSRC_HI:CTRL_REGSRC_LO] = REGSRC_ALU;
                ctrl_o[CTRL_ALUSRC0]                  = 1'b1;
                ctrl_o[CTRL_ALUSRC]                   = 1'b1;
            end
            OPC_LUI: begin
                ctrl_o[CTRL_REGWRITE]                 = 1'b1;
                ctrl_o[CTRL_REGSRC_HI:CTRL_REGSRC_LO] = REGSRC_ALU;
                ctrl_o[CTRL_ALUSRC]                   = 1'b1;
            end
            default: ;
        endcase
    end

    // Source-register usage flags feeding the load-use interlock
    always_comb begin
        uses_rs1_o = !((opcode == OPC_JAL) || (opcode == OPC_AUIPC) || (opcode == OPC_LUI));
        uses_rs2_o = (opcode == OPC_OP) || (opcode == OPC_BRANCH) || (opcode == OPC_STORE);
    end

endmodule

// File: rtl/decode_stage.sv
// Registered ID/EX stage: decode, valid/ready handshake, load-use bubble
// insertion and flush. Optional perf counters under DECODE_PERF_CNT_EN.
module decode_stage
    import cpu_ctrl_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 32,
    parameter int REG_AW = 5
`ifdef DECODE_PERF_CNT_EN
    ,
    parameter int CNT_W  = 32
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    output logic              if_ready,
    input  logic [31:0]       if_instr,
    input  logic [XLEN-1:0]   if_pc,
    input  logic              if_hit,
    input  logic              flush,
    input  logic              ex_ready,
    output logic              id_valid,
    output logic [CTRL_W-1:0] id_ctrl,
    output logic [31:0]       id_instr,
    output logic [XLEN-1:0]   id_pc,
    output logic [REG_AW-1:0] id_rs1,
    output logic [REG_AW-1:0] id_rs2,
    output logic [REG_AW-1:0] id_rd,
    output logic              stall_loaduse
`ifdef DECODE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  perf_issued,
    output logic [CNT_W-1:0]  perf_bubbles
`endif
);

    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [31:0]       instr_q, instr_d;
    logic [XLEN-1:0]   pc_q, pc_d;

    logic [CTRL_W-1:0] decodedCtrl;
    logic              usesRs1, usesRs2;
    logic              advance, accept, bubble;
    logic [REG_AW-1:0] offRs1, offRs2;

    decode_ctrl_comb #(.CTRL_W(CTRL_W)) u_ctrl (
        .instr_i    (if_instr),
        .hit_i      (if_hit),
        .ctrl_o     (decodedCtrl),
        .uses_rs1_o (usesRs1),
        .uses_rs2_o (usesRs2)
    );

    assign id_valid = valid_q;
    assign id_ctrl  = ctrl_q;
    assign id_instr = instr_q;
    assign id_pc    = pc_q;
    assign id_rs1   = REG_AW'(instr_q[19:15]);
    assign id_rs2   = REG_AW'(instr_q[24:20]);
    assign id_rd    = REG_AW'(instr_q[11:7]);
    assign offRs1   = REG_AW'(if_instr[19:15]);
    assign offRs2   = REG_AW'(if_instr[24:20]);

    // Handshake and load-use interlock: a held load whose rd feeds the offered instruction forces one bubble
    always_comb begin
        advance       = ~valid_q | ex_ready;
        stall_loaduse = valid_q & ctrl_q[CTRL_MEMREAD] & (id_rd != '0) & if_valid
                      & ((usesRs1 & (offRs1 == id_rd)) | (usesRs2 & (offRs2 == id_rd)));
        if_ready      = advance & ~stall_loaduse & ~flush;
        accept        = if_valid & if_ready;
        bubble        = advance & stall_loaduse & ~flush;
    end

    // Next-state of the pipeline register: flush beats advance; payload only changes on accept
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (advance) begin
            valid_d = accept;
            if (accept) begin
                ctrl_d  = decodedCtrl;
                instr_d = if_instr;
                pc_d    = if_pc;
            end
        end
    end

    // Pipeline register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            instr_q <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

`ifdef DECODE_PERF_CNT_EN
    logic [CNT_W-1:0] issued_q, issued_d;
    logic [CNT_W-1:0] bubbles_q, bubbles_d;

    assign perf_issued  = issued_q;
    assign perf_bubbles = bubbles_q;

    // Free-running wrap-around counters of accepts and inserted bubbles
    always_comb begin
        issued_d  = issued_q + CNT_W'(accept);
        bubbles_d = bubbles_q + CNT_W'(bubble);
    end

    // Counter registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            issued_q  <= '0;
            bubbles_q <= '0;
        end else begin
            issued_q  <= issued_d;
            bubbles_q <= bubbles_d;
        end
    end
`else
    logic unusedBubble;
    assign unusedBubble = bubble;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: directed cases with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid, if_hit, flush, ex_ready;
    logic [31:0] if_instr, if_pc;
    wire         if_ready, id_valid, stall_loaduse;
    wire  [31:0] id_ctrl, id_instr, id_pc;
    wire  [4:0]  id_rs1, id_rs2, id_rd;
`ifdef DECODE_PERF_CNT_EN
    wire  [31:0] perf_issued, perf_bubbles;
`endif

    int checks   = 0;
    int failures = 0;
    bit compareOn = 1'b0;

    // Model state: what the ID/EX register must hold
    bit          mValid;
    logic [31:0] mCtrl, mInstr, mPc;
    int unsigned mIssued, mBubbles;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk           (clk),
        .rst           (rst),
        .if_valid      (if_valid),
        .if_ready      (if_ready),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .if_hit        (if_hit),
        .flush         (flush),
        .ex_ready      (ex_ready),
        .id_valid      (id_valid),
        .id_ctrl       (id_ctrl),
        .id_instr      (id_instr),
        .id_pc         (id_pc),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_rd         (id_rd),
        .stall_loaduse (stall_loaduse)
`ifdef DECODE_PERF_CNT_EN
        ,
        .perf_issued   (perf_issued),
        .perf_bubbles  (perf_bubbles)
`endif
    );

    // Control word built as a sum of bit weights from the opcode table
    function automatic logic [31:0] modelCtrl(input logic [31:0] ins, input logic hit);
        int unsigned w;
        w = hit ? 32'h8000_0000 : 32'h0;
        case (ins[6:0])
            7'b0010011: w += 32'h40000 + 2 * 32'h10000 + 32'h10;
            7'b0110011: w += 32'h40000 + 2 * 32'h10000 + ((ins[31:25] != 0) ? 1 : 0);
            7'b1101111: w += 32'h40000 + 32'h10 + 32'h200;
            7'b1100111: w += 32'h40000 + 32'h10 + 32'h400;
            7'b1100011: w += 1 + ((ins[14:12] == 0) ? 32'h100 : 32'h800);
            7'b0000011: w += 32'h40000 + 32'h10000 + 32'h2000 + 32'h10;
            7'b0100011: w += 32'h1000 + 32'h10;
            7'b0010111: w += 32'h40000 + 2 * 32'h10000 + 32'h20 + 32'h10;
            7'b0110111: w += 32'h40000 + 2 * 32'h10000 + 32'h10;
            default:    w += 0;
        endcase
        return w;
    endfunction

    function automatic bit usesRs1(input logic [31:0] ins);
        return !(ins[6:0] == 7'b1101111 || ins[6:0] == 7'b0010111 || ins[6:0] == 7'b0110111);
    endfunction

    function automatic bit usesRs2(input logic [31:0] ins);
        return ins[6:0] == 7'b0110011 || ins[6:0] == 7'b1100011 || ins[6:0] == 7'b0100011;
    endfunction

    function automatic bit modelStall();
        logic [4:0] rd;
        rd = mInstr[11:7];
        return mValid && mCtrl[13] && rd != 0 && if_valid
            && ((usesRs1(if_instr) && if_instr[19:15] == rd) || (usesRs2(if_instr) && if_instr[24:20] == rd));
    endfunction

    function automatic bit modelReady();
        return (!mValid || ex_ready) && !modelStall() && !flush;
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model advances on every rising edge from the inputs applied that cycle
    always @(posedge clk) begin : modelUpdate
        bit st, adv;
        if (rst) begin
            mValid = 0; mCtrl = 0; mInstr = 0; mPc = 0; mIssued = 0; mBubbles = 0;
        end else begin
            st  = modelStall();
            adv = !mValid || ex_ready;
            if (flush) begin
                mValid = 0;
            end else if (adv) begin
                if (st) begin
                    mValid = 0;
                    mBubbles++;
                end else if (if_valid) begin
                    mValid = 1;
                    mCtrl  = modelCtrl(if_instr, if_hit);
                    mInstr = if_instr;
                    mPc    = if_pc;
                    mIssued++;
                end else begin
                    mValid = 0;
                end
            end
        end
    end

    task automatic checkOutput();
        checkVal("id_valid", 32'(id_valid), 32'(mValid));
        checkVal("id_ctrl", id_ctrl, mCtrl);
        checkVal("id_instr", id_instr, mInstr);
        checkVal("id_pc", id_pc, mPc);
        checkVal("id_rs1", 32'(id_rs1), 32'(mInstr[19:15]));
        checkVal("id_rs2", 32'(id_rs2), 32'(mInstr[24:20]));
        checkVal("id_rd", 32'(id_rd), 32'(mInstr[11:7]));
        checkVal("stall_loaduse", 32'(stall_loaduse), 32'(modelStall()));
        checkVal("if_ready", 32'(if_ready), 32'(modelReady()));
`ifdef DECODE_PERF_CNT_EN
        checkVal("perf_issued", perf_issued, mIssued);
        checkVal("perf_bubbles", perf_bubbles, mBubbles);
`endif
    endtask

    // Compare process: outputs against the model, mid-cycle after inputs settle
    always @(negedge clk) begin
        #3;
        if (compareOn) checkOutput();
    end

    task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                                 input logic hit, input logic fl, input logic exr);
        @(negedge clk);
        #1;
        if_valid = v; if_instr = ins; if_pc = pc; if_hit = hit; flush = fl; ex_ready = exr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] randInstr();
        logic [6:0] opc;
        logic [6:0] f7;
        case ($urandom_range(0, 9))
            0: opc = 7'b0010011;
            1: opc = 7'b0110011;
            2: opc = 7'b1101111;
            3: opc = 7'b1100111;
            4: opc = 7'b1100011;
            5: opc = 7'b0000011;
            6: opc = 7'b0000011;
            7: opc = 7'b0100011;
            8: opc = ($urandom_range(0, 1) != 0) ? 7'b0010111 : 7'b0110111;
            default: opc = 7'($urandom);
        endcase
        f7 = ($urandom_range(0, 2) == 0) ? 7'h20 : 7'h00;
        return {f7, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 3'($urandom),
                5'($urandom_range(0, 3)), opc};
    endfunction

    localparam logic [31:0] ADDI  = 32'h0050_0093;
    localparam logic [31:0] LW    = 32'h0000_A283;
    localparam logic [31:0] LW0   = 32'h0000_A003;
    localparam logic [31:0] ADD   = 32'h0072_8333;
    localparam logic [31:0] BLT   = 32'h0020_C063;

    initial begin
        rst = 1; if_valid = 0; if_instr = 0; if_pc = 0; if_hit = 0; flush = 0; ex_ready = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        rst = 0;
        compareOn = 1;
        #1;
        checkVal("reset id_valid", 32'(id_valid), 32'h0);
        checkVal("reset id_ctrl", id_ctrl, 32'h0);
        checkVal("reset if_ready", 32'(if_ready), 32'h1);

        // ADDI with hit
        applyStimulus(1, ADDI, 32'h100, 1, 0, 1);
        tick();
        checkVal("addi id_valid", 32'(id_valid), 32'h1);
        checkVal("addi id_ctrl", id_ctrl, 32'h8006_0010);
        checkVal("addi id_rd", 32'(id_rd), 32'h1);

        // LW then dependent ADD: one bubble
        applyStimulus(1, LW, 32'h104, 0, 0, 1);
        tick();
        checkVal("lw id_ctrl", id_ctrl, 32'h0005_2010);
        applyStimulus(1, ADD, 32'h108, 0, 0, 1);
        #1;
        checkVal("loaduse stall", 32'(stall_loaduse), 32'h1);
        checkVal("loaduse if_ready", 32'(if_ready), 32'h0);
        tick();
        checkVal("bubble id_valid", 32'(id_valid), 32'h0);
`ifdef DECODE_PERF_CNT_EN
        checkVal("bubble perf_bubbles", perf_bubbles, 32'h1);
`endif
        applyStimulus(1, ADD, 32'h108, 0, 0, 1);
        #1;
        checkVal("after bubble stall", 32'(stall_loaduse), 32'h0);
        tick();
        checkVal("add issued", id_instr, ADD);
        checkVal("add id_ctrl", id_ctrl, 32'h0006_0000);

        // LW x0 then ADD: no stall
        applyStimulus(1, LW0, 32'h10C, 0, 0, 1);
        tick();
        applyStimulus(1, ADD, 32'h110, 0, 0, 1);
        #1;
        checkVal("lw x0 no stall", 32'(stall_loaduse), 32'h0);
        tick();
        checkVal("lw x0 add issued", id_instr, ADD);

        // Backpressure for 3 cycles
        applyStimulus(1, ADDI, 32'h114, 0, 0, 0);
        #1;
        checkVal("backpressure if_ready", 32'(if_ready), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkVal("hold id_instr", id_instr, ADD);
            checkVal("hold id_pc", id_pc, 32'h110);
        end
        applyStimulus(1, ADDI, 32'h114, 0, 0, 1);
        tick();
        checkVal("release id_pc", id_pc, 32'h114);

        // Flush kills held and offered instruction
        applyStimulus(1, LW, 32'h118, 0, 1, 0);
        tick();
        checkVal("flush id_valid", 32'(id_valid), 32'h0);
        applyStimulus(0, 32'h0, 32'h0, 0, 0, 1);
        tick();
        checkVal("flush dropped", 32'(id_valid), 32'h0);

        // BLT sets blt and ALUop
        applyStimulus(1, BLT, 32'h200, 0, 0, 1);
        tick();
        checkVal("blt id_ctrl", id_ctrl, 32'h0000_0801);

        // Randomized traffic with occasional reset
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 9) < 7, randInstr(), $urandom, 1'($urandom),
                          $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7);
            rst = ($urandom_range(0, 99) == 0);
        end
        applyStimulus(0, 32'h0, 32'h0, 0, 0, 1);
        rst = 0;
        repeat (3) tick();
        compareOn = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
